// File: rtl/rv_core_pkg.sv
// Shared encodings for the multi-cycle RV64I-subset core: opcodes, function codes,
// FSM states, halt causes and ALU operations.
package rv_core_pkg;

  localparam logic [6:0] OpcOpImm  = 7'h13;
  localparam logic [6:0] OpcOp     = 7'h33;
  localparam logic [6:0] OpcLui    = 7'h37;
  localparam logic [6:0] OpcAuipc  = 7'h17;
  localparam logic [6:0] OpcJal    = 7'h6f;
  localparam logic [6:0] OpcJalr   = 7'h67;
  localparam logic [6:0] OpcSystem = 7'h73;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Jalr   = 3'b000;

  localparam logic [6:0] F7Add = 7'b000_0000;
  localparam logic [6:0] F7Sub = 7'b010_0000;

  localparam logic [31:0] InstEbreak = 32'h0010_0073;

  typedef enum logic [1:0] {
    StFetch,
    StDecode,
    StExec,
    StHalt
  } state_e;

  typedef enum logic [1:0] {
    HcNone       = 2'b00,
    HcEbreak     = 2'b01,
    HcIllegal    = 2'b10,
    HcMisaligned = 2'b11
  } halt_cause_e;

  typedef enum logic [1:0] {
    AluAdd,
    AluSub,
    AluPassB
  } alu_op_e;

  // J-type immediate, sign-extended to 32 bits.
  function automatic logic [31:0] imm_j32(logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/rv_regfile.sv
// 32-entry integer register file: two asynchronous read ports, one synchronous write
// port, x0 hardwired to zero, synchronous clear.
module rv_regfile #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [4:0]      raddr_a_i,
  output logic [XLEN-1:0] rdata_a_o,
  input  logic [4:0]      raddr_b_i,
  output logic [XLEN-1:0] rdata_b_o,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i
);

  logic [XLEN-1:0] regs_q [32];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == 5'd0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == 5'd0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/rv_core_mc.sv
// Multi-cycle RV64I-subset core (FETCH/DECODE/EXEC/HALT) with wait-state fetch port,
// bench instruction injection, halt/trap detection and a retire trace port.
module rv_core_mc
  import rv_core_pkg::*;
#(
  parameter int unsigned XLEN      = 64,
  parameter logic [63:0] RESET_PC  = 64'h8000_0000,
  parameter bit          INJECT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  input  logic            dbg_inject_en,
  input  logic [31:0]     dbg_inject_inst,
  output logic            retire,
  output logic [XLEN-1:0] retire_pc,
  output logic            retire_we,
  output logic [4:0]      retire_rd,
  output logic [XLEN-1:0] retire_wdata,
  output logic            halt,
  output logic [1:0]      halt_cause
);

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] op_a_q, op_b_q;
  logic [4:0]      rd_q;
  alu_op_e         alu_op_q;
  logic            jump_q, ebreak_q, illegal_q;
  logic            halt_q;
  halt_cause_e     cause_q;

  logic [XLEN-1:0] rs1_rdata, rs2_rdata;
  logic [XLEN-1:0] imm_i, imm_u, imm_j;
  logic [XLEN-1:0] dec_a, dec_b;
  alu_op_e         dec_alu;
  logic            dec_jump, dec_ebreak, dec_illegal;
  logic            inject_active;

  logic [XLEN-1:0] alu_res, jump_target, pc_plus4, exec_wdata, next_pc;
  halt_cause_e     exec_cause;
  logic            exec_halt, retire_ok, wr_en;

  rv_regfile #(
    .XLEN(XLEN)
  ) u_regfile (
    .clk_i    (clk),
    .rst_i    (rst),
    .raddr_a_i(inst_q[19:15]),
    .rdata_a_o(rs1_rdata),
    .raddr_b_i(inst_q[24:20]),
    .rdata_b_o(rs2_rdata),
    .we_i     (wr_en),
    .waddr_i  (rd_q),
    .wdata_i  (exec_wdata)
  );

  assign inject_active = INJECT_EN && dbg_inject_en && (state_q == StFetch);
  assign imem_req      = (state_q == StFetch) && !inject_active;
  assign imem_addr     = pc_q;

  assign imm_i = XLEN'($signed(inst_q[31:20]));
  assign imm_u = XLEN'($signed({inst_q[31:12], 12'h000}));
  assign imm_j = XLEN'($signed(imm_j32(inst_q)));

  // Decode: operands are muxed here so EXEC only sees a/b and an ALU op.
  always_comb begin
    dec_a       = rs1_rdata;
    dec_b       = imm_i;
    dec_alu     = AluAdd;
    dec_jump    = 1'b0;
    dec_ebreak  = 1'b0;
    dec_illegal = 1'b0;
    case (inst_q[6:0])
      OpcOpImm: dec_illegal = (inst_q[14:12] != F3AddSub);
      OpcOp: begin
        dec_b = rs2_rdata;
        if ((inst_q[14:12] == F3AddSub) && (inst_q[31:25] == F7Add)) begin
          dec_alu = AluAdd;
        end else if ((inst_q[14:12] == F3AddSub) && (inst_q[31:25] == F7Sub)) begin
          dec_alu = AluSub;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OpcLui: begin
        dec_b   = imm_u;
        dec_alu = AluPassB;
      end
      OpcAuipc: begin
        dec_a = pc_q;
        dec_b = imm_u;
      end
      OpcJal: begin
        dec_a    = pc_q;
        dec_b    = imm_j;
        dec_jump = 1'b1;
      end
      OpcJalr: begin
        dec_jump    = 1'b1;
        dec_illegal = (inst_q[14:12] != F3Jalr);
      end
      OpcSystem: begin
        if (inst_q == InstEbreak) begin
          dec_ebreak = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (alu_op_q)
      AluSub:   alu_res = op_a_q - op_b_q;
      AluPassB: alu_res = op_b_q;
      default:  alu_res = op_a_q + op_b_q;
    endcase
  end

  assign jump_target = {alu_res[XLEN-1:1], 1'b0};
  assign pc_plus4    = pc_q + XLEN'(4);
  assign exec_wdata  = jump_q ? pc_plus4 : alu_res;
  assign next_pc     = jump_q ? jump_target : pc_plus4;

  always_comb begin
    if (illegal_q) begin
      exec_cause = HcIllegal;
    end else if (ebreak_q) begin
      exec_cause = HcEbreak;
    end else if (jump_q && jump_target[1]) begin
      exec_cause = HcMisaligned;
    end else begin
      exec_cause = HcNone;
    end
  end

  assign exec_halt = (exec_cause != HcNone);
  assign retire_ok = (state_q == StExec) && !exec_halt;
  assign wr_en     = retire_ok && (rd_q != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC[XLEN-1:0];
      inst_q    <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      rd_q      <= '0;
      alu_op_q  <= AluAdd;
      jump_q    <= 1'b0;
      ebreak_q  <= 1'b0;
      illegal_q <= 1'b0;
      halt_q    <= 1'b0;
      cause_q   <= HcNone;
    end else begin
      unique case (state_q)
        StFetch: begin
          // Injection has priority over a simultaneous memory response.
          if (inject_active) begin
            inst_q  <= dbg_inject_inst;
            state_q <= StDecode;
          end else if (imem_valid) begin
            inst_q  <= imem_rdata;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          op_a_q    <= dec_a;
          op_b_q    <= dec_b;
          rd_q      <= inst_q[11:7];
          alu_op_q  <= dec_alu;
          jump_q    <= dec_jump;
          ebreak_q  <= dec_ebreak;
          illegal_q <= dec_illegal;
          state_q   <= StExec;
        end
        StExec: begin
          if (exec_halt) begin
            halt_q  <= 1'b1;
            cause_q <= exec_cause;
            state_q <= StHalt;
          end else begin
            pc_q    <= next_pc;
            state_q <= StFetch;
          end
        end
        StHalt: ;
      endcase
    end
  end

  assign retire       = retire_ok;
  assign retire_pc    = retire_ok ? pc_q : '0;
  assign retire_we    = wr_en;
  assign retire_rd    = retire_ok ? rd_q : 5'd0;
  assign retire_wdata = wr_en ? exec_wdata : '0;
  assign halt         = halt_q;
  assign halt_cause   = cause_q;

endmodule

// File: tb/tb_rv_core_mc.sv
// Directed plus randomized bench for rv_core_mc against an ISA-level reference model.
module tb_rv_core_mc;

  localparam logic [63:0] RstPc = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        dbg_inject_en;
  logic [31:0] dbg_inject_inst;
  logic        retire;
  logic [63:0] retire_pc;
  logic        retire_we;
  logic [4:0]  retire_rd;
  logic [63:0] retire_wdata;
  logic        halt;
  logic [1:0]  halt_cause;

  rv_core_mc #(
    .XLEN     (64),
    .RESET_PC (RstPc),
    .INJECT_EN(1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_valid     (imem_valid),
    .dbg_inject_en  (dbg_inject_en),
    .dbg_inject_inst(dbg_inject_inst),
    .retire         (retire),
    .retire_pc      (retire_pc),
    .retire_we      (retire_we),
    .retire_rd      (retire_rd),
    .retire_wdata   (retire_wdata),
    .halt           (halt),
    .halt_cause     (halt_cause)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_assert = 0;
  int n_fail   = 0;

  logic [63:0] m_regs [32];
  logic [63:0] m_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pc = RstPc;
  endtask

  // Architectural step: what the ISA says this instruction does from the current state.
  task automatic model_step(input logic [31:0] inst, output bit hlt, output logic [1:0] cause,
                            output bit we, output logic [4:0] rd, output logic [63:0] wd,
                            output logic [63:0] rpc);
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [63:0] a, b, immi, immu, immj, val, tgt;
    bit          legal, jump, ebrk;
    op    = inst[6:0];
    f3    = inst[14:12];
    f7    = inst[31:25];
    rd    = inst[11:7];
    a     = m_regs[inst[19:15]];
    b     = m_regs[inst[24:20]];
    immi  = {{52{inst[31]}}, inst[31:20]};
    immu  = {{32{inst[31]}}, inst[31:12], 12'h000};
    immj  = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    legal = 0; jump = 0; ebrk = 0; val = '0; tgt = '0;
    rpc   = m_pc;
    case (op)
      7'h13: begin legal = (f3 == 0); val = a + immi; end
      7'h33: begin
        legal = (f3 == 0) && (f7 == 7'h00 || f7 == 7'h20);
        val   = (f7 == 7'h00) ? a + b : a - b;
      end
      7'h37: begin legal = 1; val = immu; end
      7'h17: begin legal = 1; val = m_pc + immu; end
      7'h6f: begin legal = 1; jump = 1; tgt = m_pc + immj; val = m_pc + 4; end
      7'h67: begin legal = (f3 == 0); jump = 1; tgt = (a + immi) & ~64'h1; val = m_pc + 4; end
      7'h73: ebrk = (inst == 32'h0010_0073);
      default: ;
    endcase
    if (ebrk) cause = 2'b01;
    else if (!legal) cause = 2'b10;
    else if (jump && tgt[1:0] != 2'b00) cause = 2'b11;
    else cause = 2'b00;
    hlt = (cause != 2'b00);
    we  = !hlt && (rd != 0);
    wd  = we ? val : '0;
    if (!hlt) begin
      if (we) m_regs[rd] = val;
      m_pc = jump ? tgt : m_pc + 4;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; imem_valid = 0; dbg_inject_en = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  // Runs one instruction from a FETCH-cycle negedge; returns at the negedge after EXEC.
  task automatic run_inst(input logic [31:0] inst, input int waits, input bit inj,
                          input bit both, output bit hlt, output int ret_cyc);
    logic [1:0]  cause;
    bit          we;
    logic [4:0]  rd;
    logic [63:0] wd, rpc;
    int          v_cyc;
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, m_pc);
    imem_valid = 0;
    repeat (waits) begin
      @(negedge clk);
      chk("stall_req", imem_req, 1);
      chk("stall_addr", imem_addr, m_pc);
    end
    if (inj) begin
      dbg_inject_en = 1; dbg_inject_inst = inst;
      imem_valid = both; imem_rdata = 32'h0000_0000;
      #1;
      chk("inject_req", imem_req, 0);
    end else begin
      imem_valid = 1; imem_rdata = inst;
    end
    v_cyc = cyc;
    @(negedge clk);
    imem_valid = 0; dbg_inject_en = 0;
    chk("decode_retire", retire, 0);
    chk("decode_req", imem_req, 0);
    model_step(inst, hlt, cause, we, rd, wd, rpc);
    @(negedge clk);
    ret_cyc = cyc;
    if (!hlt) begin
      chk("retire", retire, 1);
      chk("retire_lat", ret_cyc - v_cyc, 2);
      chk("retire_pc", retire_pc, rpc);
      chk("retire_we", retire_we, we);
      chk("retire_rd", retire_rd, rd);
      chk("retire_wdata", retire_wdata, wd);
    end else begin
      chk("halt_no_retire", retire, 0);
      chk("halt_late", halt, 0);
    end
    @(negedge clk);
    if (hlt) begin
      chk("halt", halt, 1);
      chk("halt_cause", halt_cause, cause);
      chk("halt_req", imem_req, 0);
    end else begin
      chk("post_retire", retire, 0);
      chk("next_addr", imem_addr, m_pc);
      chk("no_halt", halt, 0);
    end
  endtask

  function automatic logic [31:0] gen_inst();
    logic [31:0] r;
    logic [20:0] j;
    logic [11:0] i12;
    logic [4:0]  rd, rs1, rs2;
    r   = $urandom;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 6))
      0: gen_inst = {r[11:0], rs1, 3'b000, rd, 7'h13};
      1: gen_inst = {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
      2: gen_inst = {7'h20, rs2, rs1, 3'b000, rd, 7'h33};
      3: gen_inst = {r[19:0], rd, 7'h37};
      4: gen_inst = {r[19:0], rd, 7'h17};
      5: begin
        j = 21'((int'($urandom_range(0, 511)) - 256) * 4);
        gen_inst = {j[20], j[10:1], j[11], j[19:12], rd, 7'h6f};
      end
      default: begin
        i12 = 12'((int'($urandom_range(0, 1023)) - 512) * 4);
        gen_inst = {i12, 5'd0, 3'b000, rd, 7'h67};
      end
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hlt;
    int r1, r2;
    rst = 1; imem_valid = 0; imem_rdata = '0; dbg_inject_en = 0; dbg_inject_inst = '0;

    do_reset();
    chk("rst_req", imem_req, 1);
    chk("rst_addr", imem_addr, RstPc);
    chk("rst_halt", halt, 0);
    chk("rst_cause", halt_cause, 0);
    chk("rst_retire", retire, 0);
    chk("rst_retire_pc", retire_pc, 0);
    chk("rst_retire_we", retire_we, 0);
    chk("rst_retire_rd", retire_rd, 0);
    chk("rst_retire_wdata", retire_wdata, 0);

    run_inst(32'h0050_0093, 0, 0, 0, hlt, r1);
    run_inst(32'h0010_8133, 0, 0, 0, hlt, r2);
    chk("retire_gap", r2 - r1, 3);
    chk("x2_value", m_regs[2], 64'd10);

    run_inst(32'hfff0_0093, 0, 0, 0, hlt, r1);
    chk("x1_all_ones", m_regs[1], 64'hffff_ffff_ffff_ffff);
    run_inst(32'h0070_0013, 0, 0, 0, hlt, r1);
    run_inst(32'h0000_0133, 0, 0, 0, hlt, r1);

    do_reset();
    run_inst(32'h0080_00ef, 0, 0, 0, hlt, r1);
    chk("jal_target", m_pc, 64'h8000_0008);
    run_inst(32'h1010_01e7, 1, 0, 0, hlt, r1);

    run_inst(32'h0050_0093, 3, 0, 0, hlt, r1);
    run_inst(32'h0030_0113, 0, 1, 1, hlt, r1);

    for (int n = 0; n < 60; n++) begin
      run_inst(gen_inst(), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
               bit'($urandom_range(0, 1)), hlt, r1);
      if (hlt) do_reset();
    end

    // Reset during a pending fetch drops the instruction arriving in the same cycle.
    imem_valid = 0;
    @(negedge clk);
    rst = 1; imem_valid = 1; imem_rdata = 32'h0050_0093;
    @(negedge clk);
    rst = 0; imem_valid = 0;
    model_reset();
    chk("midrst_req", imem_req, 1);
    chk("midrst_addr", imem_addr, RstPc);
    run_inst(32'h0000_8113, 0, 0, 0, hlt, r1);

    do_reset();
    run_inst(32'h0020_00ef, 0, 0, 0, hlt, r1);

    do_reset();
    run_inst(32'h0000_0000, 0, 0, 0, hlt, r1);
    repeat (3) begin
      imem_valid = 1; imem_rdata = 32'h0050_0093;
      @(negedge clk);
      chk("frozen_req", imem_req, 0);
      chk("frozen_halt", halt, 1);
      chk("frozen_retire", retire, 0);
    end
    imem_valid = 0;
    do_reset();
    chk("refetch_addr", imem_addr, RstPc);
    chk("refetch_halt", halt, 0);
    run_inst(32'h0010_0073, 0, 0, 0, hlt, r1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
